// File: rtl/vc_trace_pkg.sv
// Shared types and constants for the line-trace character buffer.
//   VC_TRACE_NCHARS : default storage depth (one full trace line)
//   CHAR_W          : width of one ASCII character
//   CHAR_NL/CHAR_SP : newline and space characters
//   trace_lb_state_e: line-tracking state of the buffer
package vc_trace_pkg;

    localparam int unsigned VC_TRACE_NCHARS = 512;
    localparam int unsigned CHAR_W          = 8;

    localparam logic [CHAR_W-1:0] CHAR_NL = 8'h0A;
    localparam logic [CHAR_W-1:0] CHAR_SP = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINE,
        S_FLUSH
    } trace_lb_state_e;

endpackage

// File: rtl/vc_trace_line_buffer_if.sv
// Character stream bundle around the line buffer: producer side (in_*) and
// drain side (out_*), both val/rdy.
//   master : the environment (producer + consumer)
//   slave  : the line buffer
interface vc_trace_line_buffer_if;
    import vc_trace_pkg::*;

    logic              in_val;
    logic              in_rdy;
    logic [CHAR_W-1:0] in_char;
    logic              in_eol;
    logic              in_abort;
    logic              out_val;
    logic              out_rdy;
    logic [CHAR_W-1:0] out_char;

    modport master (
        output in_val, in_char, in_eol, in_abort, out_rdy,
        input  in_rdy, out_val, out_char
    );

    modport slave (
        input  in_val, in_char, in_eol, in_abort, out_rdy,
        output in_rdy, out_val, out_char
    );

endinterface

// File: rtl/vc_trace_char_ram.sv
// Character storage: p_depth x CHAR_W, one synchronous write port and one
// combinational read port. The array has no reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write character
//   rd_addr : read address
//   rd_data : character at rd_addr (combinational)
module vc_trace_char_ram
    import vc_trace_pkg::*;
#(
    parameter int unsigned p_depth = VC_TRACE_NCHARS,
    localparam int unsigned AW     = $clog2(p_depth)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [p_depth];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vc_trace_line_buffer.sv
// Line-commit buffer for trace text. Characters are written at wr, become
// visible to the drain only once cmt moves past them (end-of-line beat or a
// forced commit), and are read out from rd. An abort rewinds wr to cmt.
//   clk, reset : clock, asynchronous active-high reset
//   io         : in_* producer handshake and out_* drain handshake
//   line_cnt   : committed lines including forced commits, wraps
//   ovfl       : sticky, a line was split by a forced commit
module vc_trace_line_buffer
    import vc_trace_pkg::*;
#(
    parameter int unsigned p_depth    = VC_TRACE_NCHARS,
    parameter int unsigned p_cnt_bits = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_trace_line_buffer_if.slave io,
    output logic [p_cnt_bits-1:0] line_cnt,
    output logic                  ovfl
);

    localparam int unsigned AW = $clog2(p_depth);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = p_cnt_bits;
    localparam logic [PW-1:0] DEPTH_P = PW'(p_depth);

    trace_lb_state_e state, state_nxt;

    logic [PW-1:0] wr, cmt, rd;
    logic [PW-1:0] wr_nxt, cmt_nxt;
    logic [PW-1:0] occ, pend;
    logic          in_rdy_c, out_val_c;
    logic          push, pop;
    logic          cnt_inc, set_ovfl;

    // Occupancy and pending (uncommitted) counts; the extra MSB separates full from empty
    assign occ  = wr - rd;
    assign pend = wr - cmt;

    // Handshakes
    assign in_rdy_c  = (occ != DEPTH_P) && !io.in_abort && (state != S_FLUSH);
    assign out_val_c = (rd != cmt);
    assign push      = io.in_val && in_rdy_c;
    assign pop       = out_val_c && io.out_rdy;

    assign io.in_rdy  = in_rdy_c;
    assign io.out_val = out_val_c;

    vc_trace_char_ram #(
        .p_depth (p_depth)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr[AW-1:0]),
        .wr_data (io.in_char),
        .rd_addr (rd[AW-1:0]),
        .rd_data (io.out_char)
    );

    // State and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wr       <= '0;
            cmt      <= '0;
            rd       <= '0;
            line_cnt <= '0;
            ovfl     <= 1'b0;
        end else begin
            state <= state_nxt;
            wr    <= wr_nxt;
            cmt   <= cmt_nxt;
            if (pop) begin
                rd <= rd + PW'(1);
            end
            if (cnt_inc) begin
                line_cnt <= line_cnt + CW'(1);
            end
            if (set_ovfl) begin
                ovfl <= 1'b1;
            end
        end
    end

    // Line tracking: commit, abort and forced commit of an over-long line
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr;
        cmt_nxt   = cmt;
        cnt_inc   = 1'b0;
        set_ovfl  = 1'b0;
        case (state)
            S_FLUSH: begin
                // A line that fills the whole buffer can never see its eol; commit what is there
                cmt_nxt   = wr;
                cnt_inc   = 1'b1;
                set_ovfl  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_IDLE, S_LINE: begin
                if (push) begin
                    wr_nxt = wr + PW'(1);
                    if (io.in_eol) begin
                        cmt_nxt   = wr + PW'(1);
                        cnt_inc   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (pend + PW'(1) == DEPTH_P) begin
                        state_nxt = S_FLUSH;
                    end else begin
                        state_nxt = S_LINE;
                    end
                end else if (io.in_abort && (state == S_LINE)) begin
                    wr_nxt    = cmt;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vc_trace_line_buffer.sv
// Bench for vc_trace_line_buffer: directed scenarios plus random val/rdy
// stress. A line-level model (pending line queue, committed char queue)
// predicts in_rdy, line_cnt, ovfl and the drained character stream.
module tb_vc_trace_line_buffer;
    import vc_trace_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] line_cnt;
    logic          ovfl;

    vc_trace_line_buffer_if ifc ();

    vc_trace_line_buffer #(
        .p_depth    (DEPTH),
        .p_cnt_bits (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .io       (ifc.slave),
        .line_cnt (line_cnt),
        .ovfl     (ovfl)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [7:0]    pend_q[$];   // chars of the open line
    logic [7:0]    exp_q[$];    // committed chars not yet drained
    int            cmt_n = 0;   // committed chars not yet popped (driver view)
    logic [CW-1:0] lc_m = '0;
    logic          ov_m = 1'b0;
    logic          flush_m = 1'b0;
    int            pushes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic commit_all();
        while (pend_q.size() != 0) begin
            exp_q.push_back(pend_q.pop_front());
            cmt_n++;
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        exp_q.delete();
        cmt_n   = 0;
        lc_m    = '0;
        ov_m    = 1'b0;
        flush_m = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance model at posedge
    task automatic step(input logic v, input logic [7:0] c, input logic e,
                        input logic a, input logic r);
        logic exp_rdy;
        logic acc;
        logic popd;
        ifc.in_val   = v;
        ifc.in_char  = c;
        ifc.in_eol   = e;
        ifc.in_abort = a;
        ifc.out_rdy  = r;
        @(negedge clk);
        exp_rdy = ((pend_q.size() + cmt_n) != DEPTH) && !a && !flush_m;
        chk("in_rdy", 32'(ifc.in_rdy), 32'(exp_rdy));
        chk("line_cnt", 32'(line_cnt), 32'(lc_m));
        chk("ovfl", 32'(ovfl), 32'(ov_m));
        acc  = v && ifc.in_rdy;
        popd = ifc.out_val && r;
        @(posedge clk);
        if (popd) cmt_n--;
        if (flush_m) begin
            commit_all();
            lc_m    = lc_m + 1'b1;
            ov_m    = 1'b1;
            flush_m = 1'b0;
        end else if (acc) begin
            pushes++;
            pend_q.push_back(c);
            if (e) begin
                commit_all();
                lc_m = lc_m + 1'b1;
            end else if (pend_q.size() == DEPTH) begin
                flush_m = 1'b1;
            end
        end else if (a) begin
            pend_q.delete();
        end
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, r);
    endtask

    task automatic drain();
        int n = 0;
        while (cmt_n != 0 && n < 200) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            n++;
        end
        chk("drain", 32'(cmt_n), 32'd0);
    endtask

    // Monitor: every drained char must be the head of the committed stream
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("out_val", 32'(ifc.out_val), 32'(exp_q.size() != 0));
                if (ifc.out_val && ifc.out_rdy) begin
                    if (exp_q.size() == 0) chk("out_extra", 32'(exp_q.size()), 32'd1);
                    else chk("out_char", 32'(ifc.out_char), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       v, e, a, r;
        logic [7:0] c;
        int         cyc;
        ifc.in_val   = 1'b0;
        ifc.in_char  = 8'h00;
        ifc.in_eol   = 1'b0;
        ifc.in_abort = 1'b0;
        ifc.out_rdy  = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: "ab\n" committed and streamed in order
        idle(2, 1'b1);
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h62, 1'b0, 1'b0, 1'b1);
        step(1'b1, CHAR_NL, 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);

        // 2: uncommitted "xyz" stays hidden, abort drops it, "q" survives
        step(1'b1, 8'h78, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h79, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h7A, 1'b0, 1'b0, 1'b1);
        idle(10, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h71, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // 3: full with committed data, pop frees a slot, push+pop at the limit
        for (int i = 0; i < 8; i++) step(1'b1, 8'h41 + 8'(i), i == 7, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h6D, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h6E, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h6F, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h70, 1'b1, 1'b0, 1'b1);
        drain();

        // 4: line longer than the buffer forces a commit; abort in that cycle is ignored
        for (int i = 0; i < 8; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h23, 1'b0, 1'b1, 1'b0);
        drain();
        step(1'b1, 8'h39, 1'b1, 1'b0, 1'b1);
        drain();

        // 5: asynchronous reset mid-line clears everything immediately
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h63, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h64, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h65, 1'b0, 1'b0, 1'b0);
        ifc.in_val = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_in_rdy", 32'(ifc.in_rdy), 32'd1);
        chk("rst_out_val", 32'(ifc.out_val), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        chk("rst_ovfl", 32'(ovfl), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle(5, 1'b1);

        // 6: random stress against the model
        pushes = 0;
        cyc    = 0;
        while (pushes < 10000 && cyc < 60000) begin
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 3) != 0);
            c = 8'($urandom_range(32, 126));
            step(v, c, e, a, r);
            cyc++;
        end
        chk("stress_pushes", 32'(pushes >= 10000), 32'd1);
        step(1'b1, CHAR_NL, 1'b1, 1'b0, 1'b1);
        drain();
        idle(2, 1'b1);
        chk("stream_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
